// File: rtl/imem_fetch_ctrl.sv
// Fetch-side sequencer for the byte-wide boot memory: four byte reads per 32-bit fetch,
// little-endian assembly, and a shared memory port with the boot loader's write path.
module imem_fetch_ctrl #(
    parameter int                         ADDRESS_WIDTH = 32,
    parameter int                         DATA_WIDTH    = 8,
    parameter int                         MEM_ABITS     = 12,
    parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDR     = 32'hBFC00000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_req,
    input  logic [ADDRESS_WIDTH-1:0] fetch_addr,
    output logic                     fetch_ready,
    output logic [31:0]              instr,
    output logic                     instr_valid,
    output logic                     fetch_err,
    input  logic                     ld_req,
    input  logic [ADDRESS_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0]    ld_data,
    output logic                     ld_ack,
    output logic [MEM_ABITS-1:0]     mem_addr,
    output logic                     mem_we,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    typedef enum logic [1:0] {IDLE, READ, LAST, RESP} state_t;

    state_t                 state;
    logic [1:0]             cnt;
    logic [MEM_ABITS-1:0]   base;
    logic [DATA_WIDTH-1:0]  byte0;
    logic [DATA_WIDTH-1:0]  byte1;
    logic [DATA_WIDTH-1:0]  byte2;

    logic port_free;
    logic in_window;
    logic accept;
    logic unused_ld_addr_hi;

    assign unused_ld_addr_hi = ^ld_addr[ADDRESS_WIDTH-1:MEM_ABITS];

    // The loader only gets the port between fetches; it always wins over a new fetch.
    assign port_free   = !rst && (state == IDLE || state == RESP);
    assign ld_ack      = port_free && ld_req;
    assign fetch_ready = port_free && !ld_req;
    assign accept      = fetch_req && fetch_ready;
    assign in_window   = (fetch_addr[ADDRESS_WIDTH-1:MEM_ABITS] == BASE_ADDR[ADDRESS_WIDTH-1:MEM_ABITS]);

    assign mem_we    = ld_ack;
    assign mem_wdata = ld_ack ? ld_data : '0;

    always_comb begin
        mem_addr = '0;
        if (ld_ack) begin
            mem_addr = ld_addr[MEM_ABITS-1:0];
        end else if (!rst && state == READ) begin
            // Natural MEM_ABITS-bit overflow gives the wrap at the top of the window.
            mem_addr = base + MEM_ABITS'(cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            base        <= '0;
            byte0       <= '0;
            byte1       <= '0;
            byte2       <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    state <= IDLE;
                    if (accept) begin
                        base <= fetch_addr[MEM_ABITS-1:0];
                        if (in_window) begin
                            cnt   <= '0;
                            state <= READ;
                        end else begin
                            instr       <= '0;
                            fetch_err   <= 1'b1;
                            instr_valid <= 1'b1;
                            state       <= RESP;
                        end
                    end
                end
                READ: begin
                    cnt <= cnt + 2'd1;
                    // Read data lags the address by one cycle, so capture the previous byte.
                    case (cnt)
                        2'd1:    byte0 <= mem_rdata;
                        2'd2:    byte1 <= mem_rdata;
                        2'd3:    byte2 <= mem_rdata;
                        default: ;
                    endcase
                    if (cnt == 2'd3) begin
                        state <= LAST;
                    end
                end
                LAST: begin
                    instr       <= {mem_rdata, byte2, byte1, byte0};
                    fetch_err   <= 1'b0;
                    instr_valid <= 1'b1;
                    state       <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a behavioural byte-wide synchronous memory.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ready;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fetch_err;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic [7:0]  ld_data;
    logic        ld_ack;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem [0:4095];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .instr       (instr),
        .instr_valid (instr_valid),
        .fetch_err   (fetch_err),
        .ld_req      (ld_req),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_ack      (ld_ack),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic load_byte(input logic [31:0] addr, input logic [7:0] data);
        @(negedge clk);
        ld_req = 1'b1; ld_addr = addr; ld_data = data;
        #1;
        checks++;
        if (ld_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== addr[11:0] || mem_wdata !== data || fetch_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_%h: ack=%b we=%b addr=%h wdata=%h rdy=%b, expected ack=1 we=1 addr=%h wdata=%h rdy=0",
                     addr[11:0], ld_ack, mem_we, mem_addr, mem_wdata, fetch_ready, addr[11:0], data);
        end
        @(posedge clk);
        #1 ld_req = 1'b0;
    endtask

    task automatic wait_resp(input logic [31:0] exp_instr, input logic exp_err, input int exp_lat,
                             input logic [11:0] a0, input string name);
        int lat = 0;
        int pulses = 0;
        logic [11:0] ea;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) fetch_req = 1'b0;
            #1;
            if (pulses == 0 && !exp_err && k <= 4) begin
                ea = a0 + 12'(k - 1);
                checks++;
                if (mem_addr !== ea || mem_we !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_addr%0d: mem_addr=%h we=%b, expected %h we=0", name, k, mem_addr, mem_we, ea);
                end
            end
            if (pulses == 0 && exp_err) begin
                checks++;
                if (mem_addr !== 12'h000 || mem_we !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_noaccess: mem_addr=%h we=%b, expected 000 we=0", name, mem_addr, mem_we);
                end
            end
            if (instr_valid === 1'b1) begin
                pulses++;
                if (pulses == 1) begin
                    lat = k;
                    checks++;
                    if (instr !== exp_instr || fetch_err !== exp_err) begin
                        errors++;
                        $display("FAIL %s_data: instr=%h err=%b, expected instr=%h err=%b", name, instr, fetch_err, exp_instr, exp_err);
                    end
                end
            end
        end
        checks++;
        if (pulses != 1 || lat != exp_lat) begin
            errors++;
            $display("FAIL %s_timing: pulses=%0d latency=%0d, expected pulses=1 latency=%0d", name, pulses, lat, exp_lat);
        end
        checks++;
        if (instr !== exp_instr || fetch_err !== exp_err) begin
            errors++;
            $display("FAIL %s_hold: instr=%h err=%b, expected instr=%h err=%b", name, instr, fetch_err, exp_instr, exp_err);
        end
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_instr, input logic exp_err,
                         input int exp_lat, input string name);
        @(negedge clk);
        fetch_req = 1'b1; fetch_addr = addr;
        #1;
        checks++;
        if (fetch_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready: fetch_ready=%b, expected 1", name, fetch_ready);
        end
        wait_resp(exp_instr, exp_err, exp_lat, addr[11:0], name);
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_req = 1'b1; fetch_addr = 32'hBFC00000; ld_req = 1'b1;
        ld_addr = 32'hBFC00010; ld_data = 8'h99;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (fetch_ready !== 1'b0 || ld_ack !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 12'h000 ||
            mem_wdata !== 8'h00 || instr !== 32'h0 || instr_valid !== 1'b0 || fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b ack=%b we=%b addr=%h wd=%h instr=%h v=%b err=%b, expected all zero",
                     fetch_ready, ld_ack, mem_we, mem_addr, mem_wdata, instr, instr_valid, fetch_err);
        end
        fetch_req = 1'b0; ld_req = 1'b0;
        @(negedge clk); rst = 1'b0;
        #1;
        checks++;
        if (fetch_ready !== 1'b1 || mem_addr !== 12'h000 || mem_wdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_release: rdy=%b addr=%h wd=%h, expected rdy=1 addr=000 wd=00", fetch_ready, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_fetch_basic();
        load_byte(32'hBFC00000, 8'h13);
        load_byte(32'hBFC00001, 8'h05);
        load_byte(32'hBFC00002, 8'h10);
        load_byte(32'hBFC00003, 8'h00);
        fetch(32'hBFC00000, 32'h00100513, 1'b0, 6, "basic");
    endtask

    task automatic test_wrap();
        load_byte(32'hBFC00FFE, 8'hAA);
        load_byte(32'hBFC00FFF, 8'hBB);
        load_byte(32'hBFC00000, 8'hCC);
        load_byte(32'hBFC00001, 8'hDD);
        fetch(32'hBFC00FFE, 32'hDDCCBBAA, 1'b0, 6, "wrap");
    endtask

    task automatic test_out_of_window();
        fetch(32'h00001000, 32'h00000000, 1'b1, 1, "oow");
    endtask

    task automatic test_ld_fetch_collide();
        load_byte(32'hBFC00101, 8'h11);
        load_byte(32'hBFC00102, 8'h22);
        load_byte(32'hBFC00103, 8'h33);
        @(negedge clk);
        ld_req = 1'b1; ld_addr = 32'hBFC00100; ld_data = 8'h5A;
        fetch_req = 1'b1; fetch_addr = 32'hBFC00100;
        #1;
        checks++;
        if (ld_ack !== 1'b1 || mem_we !== 1'b1 || fetch_ready !== 1'b0 || mem_addr !== 12'h100 || mem_wdata !== 8'h5A) begin
            errors++;
            $display("FAIL collide_ld: ack=%b we=%b rdy=%b addr=%h wd=%h, expected ack=1 we=1 rdy=0 addr=100 wd=5a",
                     ld_ack, mem_we, fetch_ready, mem_addr, mem_wdata);
        end
        @(negedge clk);
        ld_req = 1'b0;
        #1;
        checks++;
        if (fetch_ready !== 1'b1 || ld_ack !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL collide_accept: rdy=%b ack=%b we=%b, expected rdy=1 ack=0 we=0", fetch_ready, ld_ack, mem_we);
        end
        wait_resp(32'h3322115A, 1'b0, 6, 12'h100, "collide");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        fetch_req = 1'b1; fetch_addr = 32'hBFC00000;
        #1;
        checks++;
        if (fetch_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: fetch_ready=%b, expected 1", fetch_ready);
        end
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) fetch_addr = 32'hBFC00100;
            if (k == 7) fetch_req = 1'b0;
            #1;
            if (k == 6) begin
                checks++;
                if (instr_valid !== 1'b1 || instr !== 32'h0010DDCC || fetch_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_first: v=%b instr=%h rdy=%b, expected v=1 instr=0010ddcc rdy=1", instr_valid, instr, fetch_ready);
                end
            end else if (k == 12) begin
                checks++;
                if (instr_valid !== 1'b1 || instr !== 32'h3322115A || fetch_err !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_second: v=%b instr=%h err=%b, expected v=1 instr=3322115a err=0", instr_valid, instr, fetch_err);
                end
            end else if (k == 7) begin
                checks++;
                if (mem_addr !== 12'h100 || fetch_ready !== 1'b0 || instr_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_restart: addr=%h rdy=%b v=%b, expected addr=100 rdy=0 v=0", mem_addr, fetch_ready, instr_valid);
                end
            end
        end
    endtask

    task automatic test_ld_during_read();
        load_byte(32'hBFC00201, 8'h02);
        load_byte(32'hBFC00202, 8'h03);
        load_byte(32'hBFC00203, 8'h04);
        @(negedge clk);
        fetch_req = 1'b1; fetch_addr = 32'hBFC00100;
        #1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) fetch_req = 1'b0;
            if (k == 2) begin
                ld_req = 1'b1; ld_addr = 32'hBFC00200; ld_data = 8'h77;
            end
            if (k == 7) ld_req = 1'b0;
            #1;
            if (k >= 2 && k <= 5) begin
                checks++;
                if (ld_ack !== 1'b0 || mem_we !== 1'b0 || fetch_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ldread_stall%0d: ack=%b we=%b rdy=%b, expected all 0", k, ld_ack, mem_we, fetch_ready);
                end
            end
            if (k == 6) begin
                checks++;
                if (instr_valid !== 1'b1 || instr !== 32'h3322115A || ld_ack !== 1'b1 || mem_we !== 1'b1 ||
                    mem_addr !== 12'h200 || mem_wdata !== 8'h77) begin
                    errors++;
                    $display("FAIL ldread_resp: v=%b instr=%h ack=%b we=%b addr=%h wd=%h, expected v=1 instr=3322115a ack=1 we=1 addr=200 wd=77",
                             instr_valid, instr, ld_ack, mem_we, mem_addr, mem_wdata);
                end
            end
        end
        fetch(32'hBFC00200, 32'h04030277, 1'b0, 6, "ldread_back");
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        @(negedge clk);
        fetch_req = 1'b1; fetch_addr = 32'hBFC00000;
        #1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) fetch_req = 1'b0;
        end
        rst = 1'b1; ld_req = 1'b1; ld_addr = 32'hBFC00300; ld_data = 8'h42;
        #1;
        checks++;
        if (fetch_ready !== 1'b0 || ld_ack !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 12'h000) begin
            errors++;
            $display("FAIL rstmid_comb: rdy=%b ack=%b we=%b addr=%h, expected 0 0 0 000", fetch_ready, ld_ack, mem_we, mem_addr);
        end
        @(posedge clk); #1;
        ld_req = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || instr !== 32'h0 || fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_regs: v=%b instr=%h err=%b, expected 0 00000000 0", instr_valid, instr, fetch_err);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (fetch_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_ready: fetch_ready=%b, expected 1", fetch_ready);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            if (instr_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL rstmid_novalid: pulses=%0d, expected 0", pulses);
        end
    endtask

    initial begin
        rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0;
        ld_req = 1'b0; ld_addr = '0; ld_data = '0;
        test_reset();
        test_fetch_basic();
        test_wrap();
        test_out_of_window();
        test_ld_fetch_collide();
        test_back_to_back();
        test_ld_during_read();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
